// File: rtl/tlp_mem_req_decoder.sv
// tlp_mem_req_decoder
// Decodes 3DW memory-request TLPs from a beat stream. Memory writes are
// forwarded beat by beat through a one-entry output register with
// incrementing addresses and byte enables. Memory reads are presented as a
// single request. Everything else is consumed to eop and flagged on
// err_pulse.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a header (sop) beat, always ready
// WR_DATA   | forwarding write payload beats, counting down to the final one
// RD_ISSUE  | read request held on rd_* until rd_ready, RX stalled
// DROP      | discarding beats of a rejected TLP until eop
module tlp_mem_req_decoder #(
  parameter int DATA_WIDTH       = 256,
  parameter int MAX_PAYLOAD_SIZE = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tlp_valid,
  output logic                    tlp_ready,
  input  logic [DATA_WIDTH-1:0]   tlp_data,
  input  logic                    tlp_sop,
  input  logic                    tlp_eop,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [31:0]             wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    wr_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [31:0]             rd_addr,
  output logic [9:0]              rd_len,
  output logic [15:0]             rd_req_id,
  output logic [7:0]              rd_tag,
  output logic                    err_pulse
);

  localparam int          BE_W        = DATA_WIDTH / 8;
  localparam int          DW_PER_BEAT = DATA_WIDTH / 32;
  localparam int          BEAT_SHIFT  = $clog2(DW_PER_BEAT);
  localparam logic [31:0] BEAT_INC    = 32'(BE_W);
  localparam logic [10:0] MAX_DW      = 11'(MAX_PAYLOAD_SIZE / 4);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DATA  = 2'd1,
    RD_ISSUE = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // header fields of the current beat (only meaningful on a sop beat)
  logic [2:0]  w_fmt;
  logic [4:0]  w_type;
  logic        w_ep;
  logic [9:0]  w_len;
  logic [15:0] w_req_id;
  logic [7:0]  w_tag;
  logic [31:0] w_addr;
  logic        w_is_wr;
  logic        w_is_rd;
  logic [10:0] w_len_dw;
  logic        w_len_ok;
  logic [10:0] w_beats;

  logic        w_ready;
  logic        w_err;
  logic        w_wr_start;
  logic        w_rd_start;
  logic        w_wr_load;
  logic        w_wr_final;
  logic [BE_W-1:0] w_last_be;

  logic [10:0]           r_beat_cnt;
  logic [31:0]           r_next_addr;
  logic [BEAT_SHIFT-1:0] r_len_rem;

  logic                  r_wr_valid;
  logic [31:0]           r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [BE_W-1:0]       r_wr_be;
  logic                  r_wr_last;
  logic                  r_rd_valid;
  logic [31:0]           r_rd_addr;
  logic [9:0]            r_rd_len;
  logic [15:0]           r_rd_req_id;
  logic [7:0]            r_rd_tag;
  logic                  r_err;

  assign w_fmt    = tlp_data[95:93];
  assign w_type   = tlp_data[92:88];
  assign w_ep     = tlp_data[78];
  assign w_len    = tlp_data[73:64];
  assign w_req_id = tlp_data[63:48];
  assign w_tag    = tlp_data[47:40];
  assign w_addr   = {tlp_data[31:2], 2'b00};

  assign w_is_wr  = (w_fmt == 3'b010) && (w_type == 5'b00000);
  assign w_is_rd  = (w_fmt == 3'b000) && (w_type == 5'b00000);
  // a length field of 0 encodes 1024 DW
  assign w_len_dw = (w_len == 10'd0) ? 11'd1024 : {1'b0, w_len};
  assign w_len_ok = (w_len_dw <= MAX_DW);
  assign w_beats  = (w_len_dw + 11'(DW_PER_BEAT - 1)) >> BEAT_SHIFT;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // next-state decode, RX ready and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_err        = 1'b0;
    w_wr_start   = 1'b0;
    w_rd_start   = 1'b0;
    w_wr_load    = 1'b0;
    w_wr_final   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (tlp_valid) begin
          if (!tlp_sop) begin
            w_err = 1'b1;
          end else if (w_is_wr && !w_ep && w_len_ok && !tlp_eop) begin
            w_wr_start   = 1'b1;
            w_next_state = WR_DATA;
          end else if (w_is_rd && !w_ep && tlp_eop) begin
            w_rd_start   = 1'b1;
            w_next_state = RD_ISSUE;
          end else begin
            w_err = 1'b1;
            if (!tlp_eop) w_next_state = DROP;
          end
        end
      end
      WR_DATA: begin
        w_ready = wr_ready | ~r_wr_valid;
        if (tlp_valid && w_ready) begin
          w_wr_load  = 1'b1;
          w_wr_final = (r_beat_cnt == 11'd1);
          if (w_wr_final) begin
            if (!tlp_eop) begin
              w_err        = 1'b1;
              w_next_state = DROP;
            end else begin
              w_next_state = IDLE;
            end
          end else if (tlp_eop) begin
            // payload shorter than the header length: close the write early
            w_err        = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      RD_ISSUE: begin
        if (r_rd_valid && rd_ready) w_next_state = IDLE;
      end
      DROP: begin
        w_ready = 1'b1;
        if (tlp_valid && tlp_eop) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // final-beat byte enables: 4 bytes per remaining DW, all when the length is a whole beat multiple
  always_comb begin
    w_last_be = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_last_be[i] = (r_len_rem == '0) || (i < 4 * int'(r_len_rem));
    end
  end

  // write beat counter and running address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_next_addr <= '0;
      r_len_rem   <= '0;
    end else if (w_wr_start) begin
      r_beat_cnt  <= w_beats;
      r_next_addr <= w_addr;
      r_len_rem   <= w_len_dw[BEAT_SHIFT-1:0];
    end else if (w_wr_load) begin
      r_beat_cnt  <= r_beat_cnt - 11'd1;
      r_next_addr <= r_next_addr + BEAT_INC;
    end
  end

  // one-entry write output register, held until wr_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_be    <= '0;
      r_wr_last  <= 1'b0;
    end else if (w_wr_load) begin
      r_wr_valid <= 1'b1;
      r_wr_addr  <= r_next_addr;
      r_wr_data  <= tlp_data;
      r_wr_be    <= w_wr_final ? w_last_be : {BE_W{1'b1}};
      r_wr_last  <= w_wr_final | tlp_eop;
    end else if (wr_ready) begin
      r_wr_valid <= 1'b0;
    end
  end

  // read request register, held until rd_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_len    <= '0;
      r_rd_req_id <= '0;
      r_rd_tag    <= '0;
    end else if (w_rd_start) begin
      r_rd_valid  <= 1'b1;
      r_rd_addr   <= w_addr;
      r_rd_len    <= w_len;
      r_rd_req_id <= w_req_id;
      r_rd_tag    <= w_tag;
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid  <= 1'b0;
    end
  end

  // error strobe, one cycle per rejected beat/TLP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_err;
  end

  assign tlp_ready = w_ready;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_be     = r_wr_be;
  assign wr_last   = r_wr_last;
  assign rd_valid  = r_rd_valid;
  assign rd_addr   = r_rd_addr;
  assign rd_len    = r_rd_len;
  assign rd_req_id = r_rd_req_id;
  assign rd_tag    = r_rd_tag;
  assign err_pulse = r_err;

endmodule
